// File: rtl/cpu_pkg.sv
// Shared constants and types for the instruction memory and its boot loader.
// Sized to match cpu_core's 6-bit program counter and 16-bit instruction word.
package cpu_pkg;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 64;
   localparam int CNT_W  = 7;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [DATA_W-1:0] NOP_WORD  = 16'h0000;

   typedef enum logic [1:0] {
      LOAD_HI,
      LOAD_LO,
      RUN
   } boot_state_t;

endpackage

// File: rtl/imem_ram.sv
// Instruction RAM: DEPTH x DATA_W, one synchronous write port and one
// asynchronous read port so the single-cycle core fetches with zero latency.
module imem_ram
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   // NOTE: the array has no reset; contents survive rst and start undefined, which keeps it mappable to RAM.
   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   assign rdata = r_mem[raddr];

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader FSM and byte packer: holds cpu_core in reset while a byte image
// is written into imem_ram, then releases the core and serves fetches.
module imem_boot_loader
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_valid,
   input  logic [7:0]        ld_data,
   input  logic              ld_last,
   output logic              ld_ready,
   input  logic              boot_start,
   input  logic [ADDR_W-1:0] pc_addr,
   output logic [DATA_W-1:0] instr_out,
   output logic              core_rst,
   output logic              load_done,
   output logic [CNT_W-1:0]  load_count
);

   boot_state_t       r_state;
   logic [7:0]        r_hi_byte;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [CNT_W-1:0]  r_load_count;
   logic              r_core_rst;
   logic              r_ld_ready;
   logic              r_load_done;

   logic              w_xfer;
   logic              w_we;
   logic [DATA_W-1:0] w_wdata;
   logic [DATA_W-1:0] w_rdata;

   assign w_xfer  = ld_valid && r_ld_ready;
   // rst has priority, so an aborted low-byte transfer must not reach the RAM
   assign w_we    = w_xfer && (r_state == LOAD_LO) && !rst;
   assign w_wdata = {r_hi_byte, ld_data};

   imem_ram u_ram (
      .clk   (clk),
      .we    (w_we),
      .waddr (r_wr_addr),
      .wdata (w_wdata),
      .raddr (pc_addr),
      .rdata (w_rdata)
   );

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= LOAD_HI;
         r_hi_byte    <= 8'h00;
         r_wr_addr    <= '0;
         r_load_count <= '0;
         r_core_rst   <= 1'b1;
         r_ld_ready   <= 1'b1;
         r_load_done  <= 1'b0;
      end else begin
         case (r_state)
            LOAD_HI: begin
               if (w_xfer) begin
                  r_hi_byte <= ld_data;
                  r_state   <= LOAD_LO;
               end
            end
            LOAD_LO: begin
               if (w_xfer) begin
                  r_wr_addr    <= r_wr_addr + ADDR_W'(1);
                  r_load_count <= r_load_count + CNT_W'(1);
                  // The final word auto-terminates the load even without ld_last
                  if (ld_last || (r_wr_addr == LAST_ADDR)) begin
                     r_state     <= RUN;
                     r_core_rst  <= 1'b0;
                     r_load_done <= 1'b1;
                     r_ld_ready  <= 1'b0;
                  end else begin
                     r_state <= LOAD_HI;
                  end
               end
            end
            RUN: begin
               if (boot_start) begin
                  r_state      <= LOAD_HI;
                  r_core_rst   <= 1'b1;
                  r_load_done  <= 1'b0;
                  r_ld_ready   <= 1'b1;
                  r_wr_addr    <= '0;
                  r_load_count <= '0;
               end
            end
            default: begin
               r_state <= LOAD_HI;
            end
         endcase
      end
   end

   assign instr_out  = (r_state == RUN) ? w_rdata : NOP_WORD;
   assign ld_ready   = r_ld_ready;
   assign core_rst   = r_core_rst;
   assign load_done  = r_load_done;
   assign load_count = r_load_count;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed scenarios followed by a
// randomized phase, all compared against a word-list model of the loader.
module tb_imem_boot_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        ld_valid;
   logic [7:0]  ld_data;
   logic        ld_last;
   logic        ld_ready;
   logic        boot_start;
   logic [5:0]  pc_addr;
   logic [15:0] instr_out;
   logic        core_rst;
   logic        load_done;
   logic [6:0]  load_count;

   imem_boot_loader dut (
      .clk        (clk),
      .rst        (rst),
      .ld_valid   (ld_valid),
      .ld_data    (ld_data),
      .ld_last    (ld_last),
      .ld_ready   (ld_ready),
      .boot_start (boot_start),
      .pc_addr    (pc_addr),
      .instr_out  (instr_out),
      .core_rst   (core_rst),
      .load_done  (load_done),
      .load_count (load_count)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;
   int fails  = 0;

   // Model: running flag, pending high byte, words loaded so far, image contents
   bit          m_run     = 1'b0;
   bit          m_have_hi = 1'b0;
   logic [7:0]  m_hi      = 8'h00;
   int          m_count   = 0;
   logic [15:0] m_mem   [64];
   bit          m_known [64];

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         m_run = 1'b0; m_have_hi = 1'b0; m_count = 0;
      end else if (m_run) begin
         if (boot_start) begin
            m_run = 1'b0; m_have_hi = 1'b0; m_count = 0;
         end
      end else if (ld_valid) begin
         if (!m_have_hi) begin
            m_hi = ld_data; m_have_hi = 1'b1;
         end else begin
            m_mem[m_count]   = {m_hi, ld_data};
            m_known[m_count] = 1'b1;
            m_count++;
            m_have_hi = 1'b0;
            if (ld_last || m_count == 64) m_run = 1'b1;
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".ld_ready"},   {15'd0, ld_ready},  {15'd0, !m_run});
      chk({tag, ".core_rst"},   {15'd0, core_rst},  {15'd0, !m_run});
      chk({tag, ".load_done"},  {15'd0, load_done}, {15'd0, m_run});
      chk({tag, ".load_count"}, {9'd0, load_count}, 16'(m_count));
      if (!m_run) chk({tag, ".instr_nop"}, instr_out, 16'h0000);
      else if (m_known[pc_addr]) chk({tag, ".instr"}, instr_out, m_mem[pc_addr]);
   endtask

   task automatic tick(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic send(input string tag, input logic [7:0] b, input logic last);
      ld_valid = 1'b1; ld_data = b; ld_last = last;
      tick(tag);
      ld_valid = 1'b0; ld_last = 1'b0;
   endtask

   task automatic idle(input string tag);
      ld_valid = 1'b0; ld_data = 8'($urandom);
      tick(tag);
   endtask

   task automatic fetch(input string tag, input logic [5:0] a);
      pc_addr = a;
      #1;
      check_all(tag);
   endtask

   initial begin
      logic [7:0]  bytes [128];
      logic [15:0] saved [3];
      foreach (m_known[i]) m_known[i] = 1'b0;
      rst = 1'b1; ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
      boot_start = 1'b0; pc_addr = 6'd0;

      // Reset state
      tick("reset0");
      tick("reset1");
      chk("reset.core_rst", {15'd0, core_rst}, 16'd1);
      chk("reset.ld_ready", {15'd0, ld_ready}, 16'd1);
      rst = 1'b0;

      // Basic image with idle gaps between handshakes; ld_last on a high byte is ignored
      pc_addr = 6'd1;
      send("t1.b12", 8'h12, 1'b1);
      idle("t1.gap0");
      idle("t1.gap1");
      send("t1.b34", 8'h34, 1'b0);
      chk("t1.pre_core_rst", {15'd0, core_rst}, 16'd1);
      chk("t1.pre_instr", instr_out, 16'h0000);
      send("t1.bAB", 8'hAB, 1'b0);
      send("t1.bCD", 8'hCD, 1'b1);
      chk("t1.core_rst_low", {15'd0, core_rst}, 16'd0);
      chk("t1.count", {9'd0, load_count}, 16'd2);
      chk("t1.mem1", instr_out, 16'hABCD);
      fetch("t1.f0", 6'd0);
      chk("t1.mem0", instr_out, 16'h1234);
      send("t1.ignored", 8'h77, 1'b0);

      // Re-boot from RUN; boot_start during the load is ignored
      boot_start = 1'b1;
      tick("t3.boot");
      boot_start = 1'b0;
      chk("t3.core_rst", {15'd0, core_rst}, 16'd1);
      chk("t3.load_done", {15'd0, load_done}, 16'd0);
      chk("t3.ld_ready", {15'd0, ld_ready}, 16'd1);
      boot_start = 1'b1;
      send("t3.b5A_hi", 8'h5A, 1'b0);
      boot_start = 1'b0;
      send("t3.b5A_lo", 8'h5A, 1'b1);
      fetch("t3.f0", 6'd0);
      chk("t3.mem0", instr_out, 16'h5A5A);

      // Full image without ld_last: auto-terminates after 64 words
      boot_start = 1'b1;
      tick("t4.boot");
      boot_start = 1'b0;
      for (int i = 0; i < 128; i++) begin
         bytes[i] = 8'($urandom);
         send("t4.stream", bytes[i], 1'b0);
      end
      chk("t4.count64", {9'd0, load_count}, 16'd64);
      chk("t4.ready0", {15'd0, ld_ready}, 16'd0);
      send("t4.byte129", 8'($urandom), 1'b0);
      fetch("t4.f0", 6'd0);
      chk("t4.mem0", instr_out, {bytes[0], bytes[1]});
      fetch("t4.f63", 6'd63);
      chk("t4.mem63", instr_out, {bytes[126], bytes[127]});
      for (int a = 0; a < 64; a++) fetch("t4.sweep", 6'(a));

      // Mid-load reset after three words plus a high byte
      boot_start = 1'b1;
      tick("t5.boot");
      boot_start = 1'b0;
      for (int w = 0; w < 3; w++) begin
         saved[w] = 16'($urandom);
         send("t5.hi", saved[w][15:8], 1'b0);
         send("t5.lo", saved[w][7:0], 1'b0);
      end
      send("t5.pending", 8'($urandom), 1'b0);
      rst = 1'b1;
      tick("t5.rst");
      rst = 1'b0;
      chk("t5.count0", {9'd0, load_count}, 16'd0);
      chk("t5.ready", {15'd0, ld_ready}, 16'd1);
      send("t5.bBE", 8'hBE, 1'b1);
      chk("t5.still_held", {15'd0, core_rst}, 16'd1);
      send("t5.bEF", 8'hEF, 1'b1);
      fetch("t5.f0", 6'd0);
      chk("t5.mem0", instr_out, 16'hBEEF);
      fetch("t5.f1", 6'd1);
      chk("t5.mem1", instr_out, saved[1]);
      fetch("t5.f2", 6'd2);
      chk("t5.mem2", instr_out, saved[2]);

      // rst and boot_start together in RUN
      rst = 1'b1; boot_start = 1'b1;
      tick("t6.both");
      rst = 1'b0; boot_start = 1'b0;
      chk("t6.count0", {9'd0, load_count}, 16'd0);
      chk("t6.core_rst", {15'd0, core_rst}, 16'd1);
      chk("t6.load_done", {15'd0, load_done}, 16'd0);

      // Randomized traffic against the model
      for (int c = 0; c < 800; c++) begin
         rst        = ($urandom_range(0, 99) == 0);
         boot_start = ($urandom_range(0, 7) == 0);
         ld_valid   = ($urandom_range(0, 3) != 0);
         ld_data    = 8'($urandom);
         ld_last    = ($urandom_range(0, 11) == 0);
         pc_addr    = 6'($urandom);
         tick("rand");
      end
      rst = 1'b0; boot_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
